// File: rtl/instr_encoder.sv
// instr_encoder
//   Program-load side of the control path. Accepts decoded instruction
//   fields over a valid/ready stream, packs them into 32-bit MIPS words and
//   writes them sequentially into instruction memory starting at word 0.
//
// Parameters
//   ADDR_W  instruction-memory word-address width
//   DEPTH   number of words writable before the session is full (1..2**ADDR_W)
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   start / finish             open a load session / close it
//   in_valid / in_ready        field stream handshake (ready while RUN)
//   in_op .. in_target         decoded instruction fields
//   mem_we/mem_addr/mem_wdata  registered one-cycle memory write
//   count                      words written this session
//   full                       DEPTH words written, stream stalled
//   err_illegal                sticky: an undefined opcode was accepted
module instr_encoder #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              finish,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_shamt,
  input  logic [5:0]        in_funct,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              err_illegal
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FULL = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   ptr_reg;
  logic [ADDR_W:0]     count_reg;
  logic                mem_we_reg;
  logic [ADDR_W-1:0]   mem_addr_reg;
  logic [31:0]         mem_wdata_reg;
  logic                err_reg;

  logic [31:0]         enc_word;
  logic                enc_legal;
  logic [5:0]          i_opc;
  logic                take;
  logic                start_ok;

  // A transfer is only possible in RUN; start only matters outside RUN,
  // so the two can never act on the same edge.
  assign take     = in_valid && (state_reg == RUN);
  assign start_ok = start && (state_reg != RUN);

  // ---------------- instruction packing ----------------
  always_comb begin
    enc_word  = 32'd0;
    enc_legal = 1'b1;
    i_opc     = 6'b000000;
    case (in_op)
      4'd1:  i_opc = 6'b100011;  // LW
      4'd2:  i_opc = 6'b101011;  // SW
      4'd3:  i_opc = 6'b000100;  // BEQ
      4'd4:  i_opc = 6'b000101;  // BNE
      4'd7:  i_opc = 6'b001000;  // ADDI
      4'd8:  i_opc = 6'b001100;  // ANDI
      4'd9:  i_opc = 6'b001101;  // ORI
      4'd10: i_opc = 6'b001110;  // XORI
      4'd11: i_opc = 6'b001010;  // SLTI
      4'd12: i_opc = 6'b001011;  // SLTIU
      default: i_opc = 6'b000000;
    endcase
    case (in_op)
      4'd0:  enc_word = {6'b000000, in_rs, in_rt, in_rd, in_shamt, in_funct};
      4'd5:  enc_word = {6'b000010, in_target};
      4'd6:  enc_word = {6'b000011, in_target};
      // LUI has no source register; rs is forced to zero
      4'd13: enc_word = {6'b001111, 5'd0, in_rt, in_imm};
      4'd14, 4'd15: enc_legal = 1'b0;
      default: enc_word = {i_opc, in_rs, in_rt, in_imm};
    endcase
  end

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (start) state_next = RUN;
      RUN: begin
        // finish wins over reaching the last address; the word is still written
        if (finish) begin
          state_next = IDLE;
        end else if (take && enc_legal && (ptr_reg == LAST_ADDR)) begin
          state_next = FULL;
        end
      end
      FULL: if (start) state_next = RUN;
      default: state_next = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    in_ready = (state_reg == RUN);
    full     = (state_reg == FULL);
  end

  // ---------------- write datapath ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_reg       <= '0;
      count_reg     <= '0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= 32'd0;
      err_reg       <= 1'b0;
    end else begin
      mem_we_reg <= 1'b0;
      if (start_ok) begin
        ptr_reg   <= '0;
        count_reg <= '0;
        err_reg   <= 1'b0;
      end else if (take) begin
        if (enc_legal) begin
          mem_we_reg    <= 1'b1;
          mem_addr_reg  <= ptr_reg;
          mem_wdata_reg <= enc_word;
          count_reg     <= count_reg + (ADDR_W+1)'(1);
          // pointer parks on the last address instead of wrapping
          if (ptr_reg != LAST_ADDR) begin
            ptr_reg <= ptr_reg + ADDR_W'(1);
          end
        end else begin
          err_reg <= 1'b1;
        end
      end
    end
  end

  assign mem_we      = mem_we_reg;
  assign mem_addr    = mem_addr_reg;
  assign mem_wdata   = mem_wdata_reg;
  assign count       = count_reg;
  assign err_illegal = err_reg;

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        reset, start, finish, in_valid, in_ready;
  logic [3:0]  in_op;
  logic [4:0]  in_rs, in_rt, in_rd, in_shamt;
  logic [5:0]  in_funct;
  logic [15:0] in_imm;
  logic [25:0] in_target;
  logic        mem_we, full, err_illegal;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [8:0]  count;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;
  logic [7:0] exp_ptr = 8'd0;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  instr_encoder #(.ADDR_W(8), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .start(start), .finish(finish),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
    .in_funct(in_funct), .in_imm(in_imm), .in_target(in_target),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .count(count), .full(full), .err_illegal(err_illegal)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s = 0x%0h", name, act);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected word.
  always @(negedge clk) begin
    if (mon_en && mem_we !== 1'b0) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL write: unexpected mem_we addr=%0d data=0x%08h", mem_addr, mem_wdata);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (mem_we !== 1'b1 || mem_addr !== e.addr || mem_wdata !== e.data) begin
          errors++;
          $display("FAIL write: got we=%b addr=%0d data=0x%08h, want addr=%0d data=0x%08h",
                   mem_we, mem_addr, mem_wdata, e.addr, e.data);
        end else begin
          $display("ok   write addr=%0d data=0x%08h", mem_addr, mem_wdata);
        end
      end
    end
  end

  task automatic set_fields(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                            input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn,
                            input logic [15:0] imm, input logic [25:0] tgt);
    in_op = op; in_rs = rs; in_rt = rt; in_rd = rd; in_shamt = sh;
    in_funct = fn; in_imm = imm; in_target = tgt;
  endtask

  // One transfer; legal words are queued for the monitor at the transfer edge.
  task automatic xfer(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn,
                      input logic [15:0] imm, input logic [25:0] tgt,
                      input bit legal, input logic [31:0] word, input bit fin);
    int n;
    set_fields(op, rs, rt, rd, sh, fn, imm, tgt);
    in_valid = 1'b1;
    finish   = fin;
    n = 0;
    while (in_ready !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (in_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL handshake: in_ready=%b after %0d cycles, want 1", in_ready, n);
      in_valid = 1'b0;
      finish   = 1'b0;
      return;
    end
    if (legal) begin
      sb.push_back('{addr: exp_ptr, data: word});
      if (exp_ptr != 8'd3) exp_ptr++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    finish   = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
    exp_ptr = 8'd0;
  endtask

  task automatic pulse_finish();
    finish = 1'b1;
    @(posedge clk); #1;
    finish = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; finish = 1'b0; in_valid = 1'b0;
    set_fields(4'd0, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0);
    repeat (2) @(posedge clk);
    #1;
    mon_en = 1'b1;
    chk("rst in_ready", 32'(in_ready), 32'd0);
    chk("rst mem_we", 32'(mem_we), 32'd0);
    chk("rst mem_addr", 32'(mem_addr), 32'd0);
    chk("rst mem_wdata", mem_wdata, 32'd0);
    chk("rst count", 32'(count), 32'd0);
    chk("rst full", 32'(full), 32'd0);
    chk("rst err", 32'(err_illegal), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // 1: single ADDI
    pulse_start();
    chk("start in_ready", 32'(in_ready), 32'd1);
    xfer(4'd7, 5'd0, 5'd8, 5'd0, 5'd0, 6'd0, 16'd5, 26'd0, 1, 32'h20080005, 0);
    chk("addi mem_we", 32'(mem_we), 32'd1);
    chk("addi count", 32'(count), 32'd1);
    pulse_finish();
    chk("finish in_ready", 32'(in_ready), 32'd0);

    // 2: back-to-back R, LW, J
    pulse_start();
    chk("restart count", 32'(count), 32'd0);
    xfer(4'd0, 5'd8, 5'd9, 5'd10, 5'd0, 6'h20, 16'd0, 26'd0, 1, 32'h01095020, 0);
    xfer(4'd1, 5'd29, 5'd8, 5'd0, 5'd0, 6'd0, 16'd4, 26'd0, 1, 32'h8FA80004, 0);
    xfer(4'd5, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h10, 1, 32'h08000010, 0);
    chk("b2b count", 32'(count), 32'd3);
    pulse_finish();

    // 3: LUI masks rs
    pulse_start();
    xfer(4'd13, 5'd7, 5'd1, 5'd0, 5'd0, 6'd0, 16'h1234, 26'd0, 1, 32'h3C011234, 0);
    pulse_finish();

    // 4: illegal op mid-stream
    pulse_start();
    xfer(4'd2, 5'd2, 5'd3, 5'd0, 5'd0, 6'd0, 16'hFFFC, 26'd0, 1, 32'hAC43FFFC, 0);
    xfer(4'd15, 5'd1, 5'd1, 5'd1, 5'd1, 6'd1, 16'h1111, 26'd0, 0, 32'd0, 0);
    chk("illegal mem_we", 32'(mem_we), 32'd0);
    chk("illegal err", 32'(err_illegal), 32'd1);
    chk("illegal count", 32'(count), 32'd1);
    chk("illegal in_ready", 32'(in_ready), 32'd1);
    xfer(4'd3, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'd3, 26'd0, 1, 32'h10220003, 0);
    chk("after illegal count", 32'(count), 32'd2);
    pulse_finish();
    chk("err sticky", 32'(err_illegal), 32'd1);
    pulse_start();
    chk("start clears err", 32'(err_illegal), 32'd0);

    // 5: fill to DEPTH=4, 5th word held, resume at 0
    xfer(4'd6, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h3FFFFFF, 1, 32'h0FFFFFFF, 0);
    xfer(4'd9, 5'd4, 5'd5, 5'd0, 5'd0, 6'd0, 16'hABCD, 26'd0, 1, 32'h3485ABCD, 0);
    xfer(4'd12, 5'd31, 5'd31, 5'd0, 5'd0, 6'd0, 16'd1, 26'd0, 1, 32'h2FFF0001, 0);
    xfer(4'd0, 5'd0, 5'd3, 5'd2, 5'd4, 6'd0, 16'd0, 26'd0, 1, 32'h00031100, 0);
    chk("full flag", 32'(full), 32'd1);
    chk("full in_ready", 32'(in_ready), 32'd0);
    chk("full count", 32'(count), 32'd4);
    set_fields(4'd10, 5'd1, 5'd1, 5'd0, 5'd0, 6'd0, 16'h00FF, 26'd0);
    in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("held count", 32'(count), 32'd4);
    pulse_finish();
    chk("finish ignored in full", 32'(full), 32'd1);
    pulse_start();
    chk("restart full", 32'(full), 32'd0);
    chk("restart count2", 32'(count), 32'd0);
    xfer(4'd10, 5'd1, 5'd1, 5'd0, 5'd0, 6'd0, 16'h00FF, 26'd0, 1, 32'h382100FF, 0);

    // 6: reset drops a same-edge transfer; finish + valid
    xfer(4'd8, 5'd3, 5'd4, 5'd0, 5'd0, 6'd0, 16'h0F0F, 26'd0, 1, 32'h30640F0F, 0);
    set_fields(4'd11, 5'd5, 5'd6, 5'd0, 5'd0, 6'd0, 16'h7FFF, 26'd0);
    in_valid = 1'b1;
    reset    = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("rst2 mem_we", 32'(mem_we), 32'd0);
    chk("rst2 mem_addr", 32'(mem_addr), 32'd0);
    chk("rst2 mem_wdata", mem_wdata, 32'd0);
    chk("rst2 count", 32'(count), 32'd0);
    chk("rst2 in_ready", 32'(in_ready), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("rst2 hold mem_we", 32'(mem_we), 32'd0);
    pulse_start();
    xfer(4'd4, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'h8000, 26'd0, 1, 32'h14008000, 1);
    chk("fin+valid in_ready", 32'(in_ready), 32'd0);
    chk("fin+valid count", 32'(count), 32'd1);
    chk("fin+valid full", 32'(full), 32'd0);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
